// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: one-shot/periodic interval timer control that drives
// a carry-chain counter via load/valueIn/carryIn/clkEn and watches carryOut.
module interval_timer_ctrl #(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      nReset,
   input  logic [WIDTH-1:0]          reloadIn,
   input  logic [PRESCALE_WIDTH-1:0] prescaleIn,
   input  logic                      periodic,
   input  logic                      irqEnable,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      ack,
   input  logic                      ctrCarryOut,
   output logic [WIDTH-1:0]          ctrLoad,
   output logic [WIDTH-1:0]          ctrValueIn,
   output logic                      ctrCarryIn,
   output logic                      ctrClkEn,
   output logic                      running,
   output logic                      expiredPulse,
   output logic                      expired,
   output logic                      overrun,
   output logic                      irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [PRESCALE_WIDTH-1:0] PS_ONE = PRESCALE_WIDTH'(1);

   state_t                    state;
   state_t                    stateNext;
   logic [WIDTH-1:0]          reloadReg;
   logic [PRESCALE_WIDTH-1:0] prescaleReg;
   logic [PRESCALE_WIDTH-1:0] prescaleCnt;
   logic                      periodicReg;
   logic                      doStart;
   logic                      inLoad;
   logic                      inRun;
   logic                      tick;
   logic                      expiry;
   logic                      reloadNow;

   assign doStart = start & ~stop;
   assign inLoad  = (state == LOAD);
   assign inRun   = (state == RUN);
   assign tick    = inRun && (prescaleCnt == '0);
   assign expiry  = tick & ctrCarryOut;

   // Periodic reload rides on the expiry cycle so the next interval has no gap.
   assign reloadNow = inLoad | (expiry & periodicReg);

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    stateNext = IDLE;
         LOAD:    stateNext = RUN;
         RUN:     if (expiry && !periodicReg) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (doStart) stateNext = LOAD;
      if (stop)    stateNext = IDLE;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         reloadReg   <= '0;
         prescaleReg <= '0;
         periodicReg <= 1'b0;
      end else if (doStart) begin
         reloadReg   <= reloadIn;
         prescaleReg <= prescaleIn;
         periodicReg <= periodic;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         prescaleCnt <= '0;
      end else if (inLoad) begin
         prescaleCnt <= prescaleReg;
      end else if (inRun) begin
         if (tick) prescaleCnt <= prescaleReg;
         else      prescaleCnt <= prescaleCnt - PS_ONE;
      end
   end

   // Expiry wins over a simultaneous ack; ack alone clears both flags.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         expiredPulse <= 1'b0;
         expired      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         expiredPulse <= expiry;
         if (expiry) begin
            expired <= 1'b1;
            if (expired && !ack) overrun <= 1'b1;
         end else if (ack) begin
            expired <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

   assign ctrLoad    = {WIDTH{reloadNow}};
   assign ctrValueIn = -reloadReg;
   assign ctrCarryIn = tick;
   assign ctrClkEn   = inLoad | inRun;
   assign running    = inLoad | inRun;
   assign irq        = expired & irqEnable;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed stimulus with an expiry scoreboard,
// driving the DUT against a behavioural carry-chain counter.
module tb_interval_timer_ctrl;

   logic       clk = 1'b0;
   logic       nReset;
   logic [7:0] reloadIn;
   logic [3:0] prescaleIn;
   logic       periodic;
   logic       irqEnable;
   logic       start;
   logic       stop;
   logic       ack;
   logic       ctrCarryOut;
   logic [7:0] ctrLoad;
   logic [7:0] ctrValueIn;
   logic       ctrCarryIn;
   logic       ctrClkEn;
   logic       running;
   logic       expiredPulse;
   logic       expired;
   logic       overrun;
   logic       irq;

   interval_timer_ctrl #(.WIDTH(8), .PRESCALE_WIDTH(4)) dut (
      .clk(clk), .nReset(nReset),
      .reloadIn(reloadIn), .prescaleIn(prescaleIn),
      .periodic(periodic), .irqEnable(irqEnable),
      .start(start), .stop(stop), .ack(ack),
      .ctrCarryOut(ctrCarryOut),
      .ctrLoad(ctrLoad), .ctrValueIn(ctrValueIn),
      .ctrCarryIn(ctrCarryIn), .ctrClkEn(ctrClkEn),
      .running(running), .expiredPulse(expiredPulse),
      .expired(expired), .overrun(overrun), .irq(irq)
   );

   always #5 clk = ~clk;

   // Counter with per-bit load, carry-in increment and carry-out at all ones
   logic [7:0] cnt;
   always @(posedge clk or negedge nReset) begin
      if (!nReset) cnt <= 8'h00;
      else if (ctrClkEn)
         cnt <= (ctrValueIn & ctrLoad) |
                ((ctrCarryIn ? cnt + 8'h01 : cnt) & ~ctrLoad);
   end
   assign ctrCarryOut = ctrCarryIn & (cnt == 8'hFF);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   at;
      logic exp;
      logic ovr;
   } ev_t;
   ev_t sb[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
                  name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (nReset && expiredPulse) begin
         if (sb.size() == 0) begin
            check("unexpected expiredPulse", 32'(cyc), 32'hFFFFFFFF);
         end else begin
            ev_t e;
            e = sb.pop_front();
            check("expiry edge", 32'(cyc), 32'(e.at));
            check("expired at expiry", {31'd0, expired}, {31'd0, e.exp});
            check("overrun at expiry", {31'd0, overrun}, {31'd0, e.ovr});
         end
      end
   end

   task automatic waitTo(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Pulses start at a negedge; returns cyc as seen after the sampling edge E0
   task automatic doStart(input logic [7:0] n, input logic [3:0] p,
                          input logic per, output int e0);
      reloadIn   = n;
      prescaleIn = p;
      periodic   = per;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0    = cyc;
   endtask

   task automatic pulseAck();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
   endtask

   int e0;
   int e1;

   initial begin
      nReset = 1'b0; reloadIn = '0; prescaleIn = '0; periodic = 1'b0;
      irqEnable = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
      #1;
      check("reset outputs",
            {ctrLoad, ctrValueIn, ctrCarryIn, ctrClkEn, running,
             expiredPulse, expired, overrun, irq}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      check("idle after reset", {30'd0, running, ctrClkEn}, 32'd0);

      // One-shot N=5 P=0
      doStart(8'd5, 4'd0, 1'b0, e0);
      sb.push_back('{at: e0 + 6, exp: 1'b1, ovr: 1'b0});
      check("t1 valueIn in LOAD", 32'(ctrValueIn), 32'hFB);
      check("t1 load in LOAD", 32'(ctrLoad), 32'hFF);
      check("t1 running in LOAD", {31'd0, running}, 32'd1);
      waitTo(e0 + 1);
      check("t1 load in RUN", 32'(ctrLoad), 32'h00);
      waitTo(e0 + 6);
      check("t1 running after", {31'd0, running}, 32'd0);
      check("t1 irq masked", {31'd0, irq}, 32'd0);
      waitTo(e0 + 7);
      check("t1 pulse one cycle", {31'd0, expiredPulse}, 32'd0);
      check("t1 expired sticky", {31'd0, expired}, 32'd1);
      pulseAck();
      check("t1 ack clears", {31'd0, expired}, 32'd0);

      // Periodic N=3 P=1 with irq
      irqEnable = 1'b1;
      doStart(8'd3, 4'd1, 1'b1, e0);
      sb.push_back('{at: e0 + 7,  exp: 1'b1, ovr: 1'b0});
      sb.push_back('{at: e0 + 13, exp: 1'b1, ovr: 1'b1});
      sb.push_back('{at: e0 + 19, exp: 1'b1, ovr: 1'b1});
      check("t2 valueIn", 32'(ctrValueIn), 32'hFD);
      for (int k = 1; k <= 19; k++) begin
         waitTo(e0 + k);
         check($sformatf("t2 ctrLoad k=%0d", k), 32'(ctrLoad),
               (k == 6 || k == 12 || k == 18) ? 32'hFF : 32'h00);
         if (k == 10 || k == 18)
            check("t2 irq held", {31'd0, irq}, 32'd1);
      end
      stop = 1'b1;
      ack  = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      ack  = 1'b0;
      check("t2 stopped+acked",
            {28'd0, running, expired, overrun, irq}, 32'd0);
      irqEnable = 1'b0;

      // N=0 gives 256 ticks
      doStart(8'd0, 4'd0, 1'b0, e0);
      sb.push_back('{at: e0 + 257, exp: 1'b1, ovr: 1'b0});
      check("t3 valueIn zero", 32'(ctrValueIn), 32'h00);
      check("t3 load", 32'(ctrLoad), 32'hFF);
      waitTo(e0 + 256);
      check("t3 no early expiry", {31'd0, expired}, 32'd0);
      waitTo(e0 + 258);
      check("t3 idle after", {31'd0, running}, 32'd0);
      pulseAck();

      // Overrun and ack/expiry collision
      doStart(8'd2, 4'd0, 1'b1, e0);
      sb.push_back('{at: e0 + 3, exp: 1'b1, ovr: 1'b0});
      sb.push_back('{at: e0 + 5, exp: 1'b1, ovr: 1'b1});
      sb.push_back('{at: e0 + 7, exp: 1'b1, ovr: 1'b1});
      waitTo(e0 + 6);
      ack = 1'b1;
      @(negedge clk);
      ack  = 1'b0;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("t4 stopped flags",
            {29'd0, running, expired, overrun}, 32'b011);
      pulseAck();
      check("t4 lone ack", {30'd0, expired, overrun}, 32'd0);

      // start+stop together, then restart mid-RUN
      doStart(8'd10, 4'd0, 1'b0, e0);
      waitTo(e0 + 3);
      reloadIn = 8'd4;
      start    = 1'b1;
      stop     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("t5 stop wins", {23'd0, running, ctrLoad}, 32'd0);
      doStart(8'd10, 4'd0, 1'b0, e1);
      waitTo(e1 + 3);
      doStart(8'd4, 4'd0, 1'b0, e0);
      sb.push_back('{at: e0 + 5, exp: 1'b1, ovr: 1'b0});
      check("t5 restart load", 32'(ctrLoad), 32'hFF);
      check("t5 restart valueIn", 32'(ctrValueIn), 32'hFC);
      waitTo(e0 + 8);
      check("t5 idle after", {31'd0, running}, 32'd0);

      // Async reset mid-run
      doStart(8'd20, 4'd0, 1'b1, e0);
      waitTo(e0 + 5);
      nReset = 1'b0;
      #1;
      check("t6 async reset outputs",
            {ctrLoad, ctrValueIn, ctrCarryIn, ctrClkEn, running,
             expiredPulse, expired, overrun, irq}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      nReset = 1'b1;
      repeat (30) @(negedge clk);
      check("t6 stays idle", {30'd0, running, ctrClkEn}, 32'd0);
      check("t6 no expiry", {30'd0, expired, overrun}, 32'd0);

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
